// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF state engine: FSM encoding, lane slicing
// and the saturating add used by every neuron lane.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lif_state_t;

    // Widest membrane word the saturating helper supports.
    localparam int MAX_DW = 32;

    // Low bit of lane i inside a packed word of dw-bit lanes.
    function automatic int lane(input int i, input int dw);
        return i * dw;
    endfunction

    // Clamp a sign-extended sum into the signed dw-bit range.
    function automatic logic signed [MAX_DW-1:0] sat_dw(input logic signed [MAX_DW:0] sum,
                                                        input int dw);
        logic signed [MAX_DW:0] one;
        logic signed [MAX_DW:0] hi;
        logic signed [MAX_DW:0] lo;
        one = {{MAX_DW{1'b0}}, 1'b1};
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        if (sum > hi) begin
            return MAX_DW'(hi);
        end else if (sum < lo) begin
            return MAX_DW'(lo);
        end
        return MAX_DW'(sum);
    endfunction

endpackage

// File: rtl/lif_state_engine_lane.sv
// One neuron lane (module lif_lane): optional leak, saturating integrate, threshold and
// hard reset. Purely combinational. Leak is enabled by defining LIF_LEAK_EN.
module lif_lane
    import snn_pkg::*;
#(
    parameter int                   DW      = 16,
    parameter logic signed [DW-1:0] VTH     = 16'sd256,
    parameter int                   LEAK_SH = 3
) (
    input  logic                 first,
    input  logic signed [DW-1:0] vmem,
    input  logic signed [DW-1:0] cur,
    output logic                 spike,
    output logic signed [DW-1:0] vnew
);

`ifdef LIF_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic signed [DW-1:0] vo;
    logic signed [DW:0]   sum;
    logic signed [DW-1:0] s;

    always_comb begin
        vo = '0;
        if (!first) begin
            vo = LEAK_ON ? (vmem - (vmem >>> LEAK_SH)) : vmem;
        end
        // Sum in DW+1 bits so the clamp sees the true overflow direction.
        sum   = {vo[DW-1], vo} + {cur[DW-1], cur};
        s     = DW'(sat_dw((MAX_DW + 1)'(sum), DW));
        spike = (s >= VTH);
        vnew  = spike ? '0 : s;
    end

endmodule

// File: rtl/lif_state_engine.sv
// LIF membrane-state engine: sequences TSTEPS x GROUPS lane-words through a
// two-stage read/compute pipeline over an internal state RAM. Leak via LIF_LEAK_EN.
module lif_state_engine
    import snn_pkg::*;
#(
    parameter int                   LANES   = 10,
    parameter int                   DW      = 16,
    parameter int                   GROUPS  = 14,
    parameter int                   TSTEPS  = 32,
    parameter logic signed [DW-1:0] VTH     = 16'sd256,
    parameter int                   LEAK_SH = 3,
    localparam int                  GW      = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int                  TW      = (TSTEPS > 1) ? $clog2(TSTEPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_cur,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_spk,
    output logic [GW-1:0]         out_grp,
    output logic [TW-1:0]         out_t,
    output logic                  busy,
    output logic                  done
);

    // Handshakes: a word moves on a channel only in a cycle where valid and ready
    // are both high; valid never depends on ready, and the whole pipeline advances
    // together whenever the output register is empty or being drained.
    lif_state_t state, state_nxt;

    logic [GW-1:0]       grp;
    logic [TW-1:0]       t;
    logic                advance, accept, last_word;
    logic                s1_valid;
    logic [LANES*DW-1:0] s1_cur;
    logic [GW-1:0]       s1_grp;
    logic [TW-1:0]       s1_t;
    logic [LANES*DW-1:0] rd_data;
    logic [LANES*DW-1:0] vnew_word;
    logic [LANES-1:0]    spk_word;
    logic [LANES*DW-1:0] ram [GROUPS];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = (state == ST_RUN) && advance;
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (grp == GW'(GROUPS - 1)) && (t == TW'(TSTEPS - 1));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last_word) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready && !s1_valid) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            grp   <= '0;
            t     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                grp <= '0;
                t   <= '0;
            end else if (accept) begin
                if (grp == GW'(GROUPS - 1)) begin
                    grp <= '0;
                    t   <= (t == TW'(TSTEPS - 1)) ? '0 : t + 1'b1;
                end else begin
                    grp <= grp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_cur    <= '0;
            s1_grp    <= '0;
            s1_t      <= '0;
            out_valid <= 1'b0;
            out_spk   <= '0;
            out_grp   <= '0;
            out_t     <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_cur <= in_cur;
                s1_grp <= grp;
                s1_t   <= t;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_spk <= spk_word;
                out_grp <= s1_grp;
                out_t   <= s1_t;
            end
        end
    end

    // State RAM is never cleared; t==0 masks whatever a previous frame left behind.
    // A read of the group being written this edge takes the new value directly.
    always_ff @(posedge clk) begin
        if (rst && advance && s1_valid) begin
            ram[s1_grp] <= vnew_word;
        end
        if (rst && accept) begin
            rd_data <= (s1_valid && (s1_grp == grp)) ? vnew_word : ram[grp];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = lane(i, DW);
        lif_lane #(
            .DW      (DW),
            .VTH     (VTH),
            .LEAK_SH (LEAK_SH)
        ) u_lane (
            .first (s1_t == '0),
            .vmem  (rd_data[LO +: DW]),
            .cur   (s1_cur[LO +: DW]),
            .spike (spk_word[i]),
            .vnew  (vnew_word[LO +: DW])
        );
    end

endmodule

// File: tb/tb_lif_state_engine.sv
// Bench for lif_state_engine: a single-group engine (forwarding, saturation, stall)
// and a 14-group engine (frame end, restart, abort). Expectations follow LIF_LEAK_EN.
module tb_lif_state_engine;

    localparam int LANES = 10;
    localparam int DW    = 16;
    localparam int CW    = LANES * DW;

`ifdef LIF_LEAK_EN
    localparam logic [9:0] A_T2 = 10'h000;
    localparam logic [9:0] B_T2 = 10'h006;
    localparam logic [9:0] F_T1 = 10'h000;
`else
    localparam logic [9:0] A_T2 = 10'h3FF;
    localparam logic [9:0] B_T2 = 10'h004;
    localparam logic [9:0] F_T1 = 10'h0FF;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic            s_rst, s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic            s_busy, s_done;
    logic [CW-1:0]   s_in_cur;
    logic [9:0]      s_out_spk;
    logic [0:0]      s_out_grp;
    logic [1:0]      s_out_t;

    logic            f_rst, f_start, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic            f_busy, f_done;
    logic [CW-1:0]   f_in_cur;
    logic [9:0]      f_out_spk;
    logic [3:0]      f_out_grp;
    logic [0:0]      f_out_t;

    logic [15:0] exp_s_q[$];
    logic [15:0] exp_f_q[$];
    logic        s_done_due = 1'b0;
    logic        f_done_due = 1'b0;
    int          s_hs = 0;
    int          f_hs = 0;

    lif_state_engine #(
        .LANES(LANES), .DW(DW), .GROUPS(1), .TSTEPS(4), .VTH(16'sd256), .LEAK_SH(1)
    ) dut_s (
        .clk(clk), .rst(s_rst), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_cur(s_in_cur), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_spk(s_out_spk), .out_grp(s_out_grp),
        .out_t(s_out_t), .busy(s_busy), .done(s_done)
    );

    lif_state_engine #(
        .LANES(LANES), .DW(DW), .GROUPS(14), .TSTEPS(2), .VTH(16'sh7FFF), .LEAK_SH(1)
    ) dut_f (
        .clk(clk), .rst(f_rst), .start(f_start), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .in_cur(f_in_cur), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_spk(f_out_spk), .out_grp(f_out_grp),
        .out_t(f_out_t), .busy(f_busy), .done(f_done)
    );

    function automatic logic [15:0] pack(input logic [9:0] spk, input logic [3:0] g,
                                         input logic [1:0] tt);
        return {spk, g, tt};
    endfunction

    function automatic logic [CW-1:0] all_lanes(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [CW-1:0] set_lane(input logic [CW-1:0] w, input int i,
                                               input logic [15:0] v);
        logic [CW-1:0] r;
        r = w;
        r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitors: pop and compare on each output handshake; check the done pulse.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!s_rst) begin
            s_done_due = 1'b0;
        end else begin
            if (s_done_due) begin
                check("s_done_pulse", 32'(s_done), 32'd1);
                check("s_frame_outputs", s_hs, 4);
                s_done_due = 1'b0;
            end else if (s_done) begin
                check("s_done_spurious", 32'(s_done), 32'd0);
            end
            if (s_out_valid && s_out_ready) begin
                s_hs++;
                if (exp_s_q.size() == 0) begin
                    fail_now("s_unexpected_output");
                end else begin
                    e = exp_s_q.pop_front();
                    check("s_out", {s_out_spk, 3'b000, s_out_grp, s_out_t}, 32'(e));
                    if (e[5:2] == 4'd0 && e[1:0] == 2'd3) s_done_due = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (!f_rst) begin
            f_done_due = 1'b0;
        end else begin
            if (f_done_due) begin
                check("f_done_pulse", 32'(f_done), 32'd1);
                check("f_frame_outputs", f_hs, 28);
                f_done_due = 1'b0;
            end else if (f_done) begin
                check("f_done_spurious", 32'(f_done), 32'd0);
            end
            if (f_out_valid && f_out_ready) begin
                f_hs++;
                if (exp_f_q.size() == 0) begin
                    fail_now("f_unexpected_output");
                end else begin
                    e = exp_f_q.pop_front();
                    check("f_out", {f_out_spk, f_out_grp, 1'b0, f_out_t}, 32'(e));
                    if (e[5:2] == 4'd13 && e[1:0] == 2'd1) f_done_due = 1'b1;
                end
            end
        end
    end

    task automatic s_send(input logic [CW-1:0] cur, input logic [15:0] e);
        int k = 0;
        s_in_cur   = cur;
        s_in_valid = 1'b1;
        @(negedge clk);
        while (!s_in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!s_in_ready) begin
            fail_now("s_accept_timeout");
        end else begin
            exp_s_q.push_back(e);
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic f_send(input logic [CW-1:0] cur, input logic [15:0] e);
        int k = 0;
        f_in_cur   = cur;
        f_in_valid = 1'b1;
        @(negedge clk);
        while (!f_in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!f_in_ready) begin
            fail_now("f_accept_timeout");
        end else begin
            exp_f_q.push_back(e);
            @(posedge clk);
            #1;
        end
        f_in_valid = 1'b0;
    endtask

    task automatic s_wait_idle();
        int k = 0;
        while (s_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("s_frame_end_idle", 32'(s_busy), 32'd0);
        check("s_queue_drained", exp_s_q.size(), 0);
    endtask

    task automatic f_wait_idle();
        int k = 0;
        while (f_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("f_frame_end_idle", 32'(f_busy), 32'd0);
        check("f_queue_drained", exp_f_q.size(), 0);
    endtask

    task automatic s_run_frame(input logic [CW-1:0] c0, c1, c2, c3,
                               input logic [9:0] k0, k1, k2, k3, input bit poke);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_hs    = 0;
        s_send(c0, pack(k0, 4'd0, 2'd0));
        if (poke) s_start = 1'b1;
        s_send(c1, pack(k1, 4'd0, 2'd1));
        s_send(c2, pack(k2, 4'd0, 2'd2));
        s_start = 1'b0;
        s_send(c3, pack(k3, 4'd0, 2'd3));
        s_wait_idle();
    endtask

    task automatic f_run_frame(input int words, input logic [CW-1:0] c0, c1);
        f_start = 1'b1;
        @(posedge clk);
        #1;
        f_start = 1'b0;
        f_hs    = 0;
        for (int tt = 0; tt < 2; tt++) begin
            for (int g = 0; g < 14; g++) begin
                if (tt * 14 + g < words) begin
                    f_send((tt == 0) ? c0 : c1,
                           pack((tt == 0) ? 10'h200 : F_T1, 4'(g), 2'(tt)));
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [CW-1:0] a_cur, b0, b1, b2, b3, f0, f1;
        int k;

        s_rst = 1'b0; s_start = 1'b0; s_in_valid = 1'b1; s_in_cur = '0; s_out_ready = 1'b1;
        f_rst = 1'b0; f_start = 1'b0; f_in_valid = 1'b1; f_in_cur = '0; f_out_ready = 1'b1;

        // Reset held with in_valid high: engine stays idle and silent.
        repeat (3) begin
            @(negedge clk);
            check("s_reset_in_ready", 32'(s_in_ready), 32'd0);
            check("s_reset_out_valid", 32'(s_out_valid), 32'd0);
            check("s_reset_busy", 32'(s_busy), 32'd0);
            check("s_reset_done", 32'(s_done), 32'd0);
            check("f_reset_in_ready", 32'(f_in_ready), 32'd0);
            check("f_reset_busy", 32'(f_busy), 32'd0);
        end
        check("s_reset_out_fields", {s_out_spk, s_out_grp, s_out_t}, 32'd0);
        @(posedge clk);
        #1;
        s_rst = 1'b1;
        f_rst = 1'b1;
        @(negedge clk);
        check("s_idle_in_ready", 32'(s_in_ready), 32'd0);
        check("s_idle_busy", 32'(s_busy), 32'd0);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        f_in_valid = 1'b0;

        // Integrate and fire with GROUPS=1 (every read is forwarded); start poked mid-run.
        a_cur = all_lanes(16'd100);
        s_run_frame(a_cur, a_cur, a_cur, a_cur, 10'h000, 10'h000, A_T2, 10'h000, 1'b1);

        // Saturation: lane0 positive clamp, lane1 negative clamp, lane2 full-scale.
        b0 = set_lane(set_lane(set_lane('0, 0, 16'd200), 1, 16'h8000), 2, 16'h7FFF);
        b1 = set_lane(set_lane(set_lane('0, 0, 16'h7FFF), 1, 16'h8000), 2, 16'h7FFF);
        b2 = set_lane(set_lane('0, 1, 16'h7FFF), 2, 16'h7FFF);
        b3 = set_lane(set_lane('0, 1, 16'd257), 2, 16'h7FFF);
        s_run_frame(b0, b1, b2, b3, 10'h004, 10'h005, B_T2, 10'h006, 1'b0);

        // Backpressure: out_ready low for 5 cycles once the first word is presented.
        fork
            s_run_frame(a_cur, a_cur, a_cur, a_cur, 10'h000, 10'h000, A_T2, 10'h000, 1'b0);
            begin
                k = 0;
                while (!s_busy && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk);
                @(posedge clk);
                #1;
                s_out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("s_stall_out_valid", 32'(s_out_valid), 32'd1);
                    check("s_stall_in_ready", 32'(s_in_ready), 32'd0);
                    if (exp_s_q.size() > 0) begin
                        check("s_stall_hold", {s_out_spk, 3'b000, s_out_grp, s_out_t},
                              32'(exp_s_q[0]));
                    end else begin
                        fail_now("s_stall_queue_empty");
                    end
                end
                @(posedge clk);
                #1;
                s_out_ready = 1'b1;
            end
        join

        // Full 14x2 frame, then a restart that must ignore the leftover RAM.
        f0 = set_lane(all_lanes(16'h4000), 9, 16'h7FFF);
        f1 = set_lane(set_lane(all_lanes(16'h4000), 8, 16'h1000), 9, 16'h0000);
        f_run_frame(28, f0, f1);
        f_wait_idle();
        f_run_frame(28, f0, f1);
        f_wait_idle();

        // Abort at t=1, grp=5, then a fresh frame.
        f_run_frame(19, f0, f1);
        f_rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_f_q.delete();
        @(negedge clk);
        check("f_abort_busy", 32'(f_busy), 32'd0);
        check("f_abort_out_valid", 32'(f_out_valid), 32'd0);
        check("f_abort_done", 32'(f_done), 32'd0);
        @(posedge clk);
        #1;
        f_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        f_run_frame(28, f0, f1);
        f_wait_idle();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
